ift_mem_arbiter: RTL and testbench
==================================

# ift_mem_arbiter

Two-requester arbiter with taint propagation that shares the single-port instruction/data SRAM (`ift_sram_mem`, 1-cycle read latency) between the core memory port (requester 0) and the harness loader/checker port (requester 1). It sits between `boom_mem_top`'s mem interface plus the loader and the SRAM. Requester 0 has fixed priority; a wait counter bounds starvation of requester 1. Read data and the taint shadows of all fields are routed back to the owner of each granted read.

## Interface
- `AddrWidth`, 32, byte address width
- `DataWidth`, 64, data width
- `StrbWidth`, `DataWidth>>3`, byte-strobe width
- `MaxWait`, 15, max consecutive lost cycles for requester 1 before forced grant; legal range 1..255
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_i`  in  [1:0]  per-requester request
- `we_i`  in  [1:0]  per-requester write enable
- `addr_i`  in  [1:0][AddrWidth]  per-requester address
- `wdata_i`  in  [1:0][DataWidth]  per-requester write data
- `strb_i`  in  [1:0][StrbWidth]  per-requester strobes
- `gnt_o`  out  [1:0]  grant, one-hot or zero
- `rvalid_o`  out  [1:0]  read data valid for requester i
- `rdata_o`  out  [DataWidth]  read data, shared bus
- `req_i_t0`, `we_i_t0`, `addr_i_t0`, `wdata_i_t0`, `strb_i_t0`  in  same widths  taint shadows
- `gnt_o_t0`, `rvalid_o_t0`  out  [1:0]  taint shadows
- `rdata_o_t0`  out  [DataWidth]  taint shadow
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_strb_o`  out  1/1/AddrWidth/DataWidth/StrbWidth  SRAM request
- `mem_rdata_i`  in  [DataWidth]  SRAM read data, valid the cycle after the request
- `mem_*_t0`  out/in  matching widths  taint shadows of all mem ports

## Operation
- Arbitration is combinational. Requester 0 wins unless `force1`, defined as `req_i[1] && wait_q == MaxWait`, in which case requester 1 wins.
- `mem_req_o = |req_i`. Other mem fields come from the winner; they are zero when no request is present.
- `wait_q` increments each cycle where `req_i[1] && !gnt_o[1]` and saturates at MaxWait. It clears on `gnt_o[1]` or whenever `!req_i[1]`.
- On a granted read, register `pend_q = 1` and `owner_q = winner`. The next cycle drives `rvalid_o[owner_q] = 1` and `rdata_o = mem_rdata_i`.
- Writes complete on grant and produce no rvalid.
- `rdata_o` is zero when no rvalid is asserted.
- Taint rules:
  - `mem_*_t0` equal the winner's taint fields.
  - `mem_req_o_t0` is the OR-taint of `req_i`: `(t0[0]&~req[1])|(t0[1]&~req[0])|(t0[0]&t0[1])`.
  - `gnt_o_t0[i] = req_i_t0[i] | (req_i[1-i] & req_i_t0[1-i])`.
  - `rvalid_o_t0` is the registered `gnt_o_t0` of the owner.
  - `rdata_o_t0 = mem_rdata_i_t0` while rvalid is asserted, else zero.
- `wait_q` carries no taint.

## Timing
- Reset values: `wait_q=0`, `pend_q=0`, `owner_q=0`, `gnt_t0_q=0`. Hence `rvalid_o=0`, `rvalid_o_t0=0`, `rdata_o=0`, `rdata_o_t0=0`.
- Grant latency is 0 cycles: grant is in the same cycle as the request.
- Read data latency is 1 cycle after grant.
- Back-to-back reads from alternating owners are sustained at one per cycle. `rvalid_o` follows the grant pattern delayed by 1 cycle.
- When both requesters request and `wait_q<MaxWait`, requester 0 wins. When `wait_q==MaxWait`, requester 1 wins even if requester 0 is requesting. `wait_q` clears the same cycle.
- With requester 1 continuously contending against continuous requester 0, requester 1 is granted exactly once every MaxWait+1 cycles.
- Dropping `req_i[1]` while it waits clears the counter; no grant is retained.
- Reset asserted with a read in flight: the pending rvalid is discarded, and no rvalid appears after reset release.

## Structure
- Package `ift_mem_arb_pkg`:
  - `NumReq=2`
  - `ReqCore=0`, `ReqLoader=1`
  - `function or_taint2(a, a_t0, b, b_t0)`
  - `typedef mem_req_t` (we, addr, wdata, strb)
- Sub-module `ift_arb_wait_cnt`: saturating counter with clear. Parameter MaxWait; output `at_max`.
- The mux and response-routing logic stay in the top module.

## Test plan
- Requester 0 only reads addr 0x80000000 and SRAM returns 0xDEADBEEF: `gnt_o=01` in cycle 0, then `rvalid_o=01` and `rdata_o=0xDEADBEEF` in cycle 1.
- Both requesters hold `req` continuously with MaxWait=3: `gnt_o[1]` asserts in cycles 3, 7, 11, …; requester 0 is granted in all other cycles.
- Requester 1 requests for 2 cycles, drops, then re-requests: `wait_q` returns to 0 and the next forced grant occurs only after 3 more lost cycles.
- Alternating read/write (0 read, 1 write, 0 read): `rvalid_o` asserts only for the reads, routed to requester 0, with no rvalid for the write.
- `req_i_t0[1]=1` while both request: `gnt_o_t0=11` and `mem_req_o_t0=0`. Requester 1 alone with `req_i_t0[1]=1`: `mem_req_o_t0=1`. `mem_rdata_i_t0=0xFF` on a granted read yields `rdata_o_t0=0xFF` the next cycle.
- Assert `rst_ni=0` in the cycle after a read grant: `rvalid_o=0` immediately (asynchronous), and all registers are zero after release.

Source files
------------

// File: rtl/ift_mem_arb_pkg.sv
// ============================================================================
// Module  : ift_mem_arb_pkg
// Brief   : Shared constants, request record and taint helper for the
//           instruction/data SRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ift_mem_arb_pkg;

  localparam int NumReq    = 2;
  localparam int ReqCore   = 0;
  localparam int ReqLoader = 1;

  // Request record at the default 32-bit address / 64-bit data configuration.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } mem_req_t;

  // Taint of (a | b): a tainted operand only matters when the other side
  // does not already force the result high.
  function automatic logic or_taint2(input logic a, input logic a_t0,
                                     input logic b, input logic b_t0);
    return (a_t0 & ~b) | (b_t0 & ~a) | (a_t0 & b_t0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ift_arb_wait_cnt.sv
// ============================================================================
// Module  : ift_arb_wait_cnt
// Brief   : Saturating starvation counter with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ift_arb_wait_cnt #(
  parameter int unsigned MaxWait = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [7:0] c_max = 8'(MaxWait);

  logic [7:0] r_cnt;
  logic       w_at_max;

  assign w_at_max = (r_cnt == c_max);
  assign at_max_o = w_at_max;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_at_max) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ift_mem_arbiter.sv
// ============================================================================
// Module  : ift_mem_arbiter
// Brief   : Fixed-priority two-requester SRAM arbiter with bounded starvation
//           of the loader port and taint propagation on every field.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ift_mem_arbiter
  import ift_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth >> 3,
  parameter int unsigned MaxWait   = 15
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,

  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]    strb_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,

  input  logic [NumReq-1:0]                   req_i_t0,
  input  logic [NumReq-1:0]                   we_i_t0,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i_t0,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i_t0,
  input  logic [NumReq-1:0][StrbWidth-1:0]    strb_i_t0,
  output logic [NumReq-1:0]                   gnt_o_t0,
  output logic [NumReq-1:0]                   rvalid_o_t0,
  output logic [DataWidth-1:0]                rdata_o_t0,

  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [StrbWidth-1:0]                mem_strb_o,
  input  logic [DataWidth-1:0]                mem_rdata_i,

  output logic                                mem_req_o_t0,
  output logic                                mem_we_o_t0,
  output logic [AddrWidth-1:0]                mem_addr_o_t0,
  output logic [DataWidth-1:0]                mem_wdata_o_t0,
  output logic [StrbWidth-1:0]                mem_strb_o_t0,
  input  logic [DataWidth-1:0]                mem_rdata_i_t0
);

  logic              w_at_max;
  logic              w_force1;
  logic              w_any;
  logic              w_sel;
  logic              w_rd_gnt;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic [NumReq-1:0] w_gnt;

  logic              r_pend;
  logic              r_owner;
  logic [NumReq-1:0] r_gnt_t0;

  // ---------------------------------------------------------------- arbitration
  assign w_force1 = req_i[ReqLoader] & w_at_max;
  assign w_any    = |req_i;

  always_comb begin
    w_gnt = '0;
    if (w_force1) begin
      w_gnt[ReqLoader] = 1'b1;
    end else if (req_i[ReqCore]) begin
      w_gnt[ReqCore] = 1'b1;
    end else if (req_i[ReqLoader]) begin
      w_gnt[ReqLoader] = 1'b1;
    end
  end

  assign w_sel = w_gnt[ReqLoader];
  assign gnt_o = w_gnt;

  assign w_wait_inc = req_i[ReqLoader] & ~w_gnt[ReqLoader];
  assign w_wait_clr = w_gnt[ReqLoader] | ~req_i[ReqLoader];

  ift_arb_wait_cnt #(
    .MaxWait (MaxWait)
  ) u_wait_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (w_wait_clr),
    .inc_i    (w_wait_inc),
    .at_max_o (w_at_max)
  );

  // ---------------------------------------------------------------- request mux
  always_comb begin
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_strb_o     = '0;
    mem_we_o_t0    = 1'b0;
    mem_addr_o_t0  = '0;
    mem_wdata_o_t0 = '0;
    mem_strb_o_t0  = '0;
    if (w_any) begin
      mem_we_o       = we_i[w_sel];
      mem_addr_o     = addr_i[w_sel];
      mem_wdata_o    = wdata_i[w_sel];
      mem_strb_o     = strb_i[w_sel];
      mem_we_o_t0    = we_i_t0[w_sel];
      mem_addr_o_t0  = addr_i_t0[w_sel];
      mem_wdata_o_t0 = wdata_i_t0[w_sel];
      mem_strb_o_t0  = strb_i_t0[w_sel];
    end
  end

  assign mem_req_o    = w_any;
  assign mem_req_o_t0 = or_taint2(req_i[ReqCore], req_i_t0[ReqCore],
                                  req_i[ReqLoader], req_i_t0[ReqLoader]);

  // A grant is tainted by its own request or by a tainted competing request.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt_t0
    assign gnt_o_t0[gi] = req_i_t0[gi] | (req_i[NumReq-1-gi] & req_i_t0[NumReq-1-gi]);
  end

  // ---------------------------------------------------------------- response path
  assign w_rd_gnt = w_any & ~we_i[w_sel];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend   <= 1'b0;
      r_owner  <= 1'b0;
      r_gnt_t0 <= '0;
    end else begin
      r_pend   <= w_rd_gnt;
      r_gnt_t0 <= gnt_o_t0;
      if (w_rd_gnt) begin
        r_owner <= w_sel;
      end
    end
  end

  always_comb begin
    rvalid_o    = '0;
    rvalid_o_t0 = '0;
    rdata_o     = '0;
    rdata_o_t0  = '0;
    if (r_pend) begin
      rvalid_o[r_owner]    = 1'b1;
      rvalid_o_t0[r_owner] = r_gnt_t0[r_owner];
      rdata_o              = mem_rdata_i;
      rdata_o_t0           = mem_rdata_i_t0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ift_mem_arbiter.sv
// ============================================================================
// Module  : tb_ift_mem_arbiter
// Brief   : Directed and randomized self-checking bench for ift_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ift_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int SW   = 8;
  localparam int MAXW = 3;

  logic clk;
  logic rst_n;

  logic [1:0]          req, we, req_t0, we_t0;
  logic [1:0][AW-1:0]  addr, addr_t0;
  logic [1:0][DW-1:0]  wdata, wdata_t0;
  logic [1:0][SW-1:0]  strb, strb_t0;
  logic [DW-1:0]       mrdata, mrdata_t0;

  logic [1:0]          gnt, gnt_t0, rvalid, rvalid_t0;
  logic [DW-1:0]       rdata, rdata_t0;
  logic                mreq, mreq_t0, mwe, mwe_t0;
  logic [AW-1:0]       maddr, maddr_t0;
  logic [DW-1:0]       mwdata, mwdata_t0;
  logic [SW-1:0]       mstrb, mstrb_t0;

  int n_tests;
  int n_fail;

  // Reference state: lost-cycle count, outstanding read and its owner/taint.
  int         m_wait;
  bit         m_pend;
  int         m_owner;
  logic [1:0] m_gt0;

  ift_mem_arbiter #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .StrbWidth (SW),
    .MaxWait   (MAXW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .strb_i         (strb),
    .gnt_o          (gnt),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .req_i_t0       (req_t0),
    .we_i_t0        (we_t0),
    .addr_i_t0      (addr_t0),
    .wdata_i_t0     (wdata_t0),
    .strb_i_t0      (strb_t0),
    .gnt_o_t0       (gnt_t0),
    .rvalid_o_t0    (rvalid_t0),
    .rdata_o_t0     (rdata_t0),
    .mem_req_o      (mreq),
    .mem_we_o       (mwe),
    .mem_addr_o     (maddr),
    .mem_wdata_o    (mwdata),
    .mem_strb_o     (mstrb),
    .mem_rdata_i    (mrdata),
    .mem_req_o_t0   (mreq_t0),
    .mem_we_o_t0    (mwe_t0),
    .mem_addr_o_t0  (maddr_t0),
    .mem_wdata_o_t0 (mwdata_t0),
    .mem_strb_o_t0  (mstrb_t0),
    .mem_rdata_i_t0 (mrdata_t0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 0;
    m_pend  = 0;
    m_owner = 0;
    m_gt0   = '0;
  endtask

  task automatic idle();
    req = '0; we = '0; req_t0 = '0; we_t0 = '0;
    addr = '0; addr_t0 = '0; wdata = '0; wdata_t0 = '0;
    strb = '0; strb_t0 = '0; mrdata = '0; mrdata_t0 = '0;
  endtask

  task automatic randomize_inputs();
    req[0] = ($urandom_range(0, 1) == 1);
    req[1] = ($urandom_range(0, 3) != 0);
    we     = 2'($urandom_range(0, 3));
    req_t0 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    we_t0  = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      addr[i]     = $urandom;
      addr_t0[i]  = $urandom;
      wdata[i]    = {$urandom, $urandom};
      wdata_t0[i] = {$urandom, $urandom};
      strb[i]     = 8'($urandom_range(0, 255));
      strb_t0[i]  = 8'($urandom_range(0, 255));
    end
    mrdata    = {$urandom, $urandom};
    mrdata_t0 = {$urandom, $urandom};
  endtask

  // One clock cycle: check every output mid-cycle against the model, then
  // advance the model across the rising edge. xg >= 0 adds a plan-level
  // grant expectation.
  task automatic step(input int xg);
    int          w;
    logic [1:0]  eg, egt, erv, ervt;
    logic        emt, e_we, e_we_t0;
    logic [AW-1:0] e_addr, e_addr_t0;
    logic [DW-1:0] e_wd, e_wd_t0;
    logic [SW-1:0] e_st, e_st_t0;
    int          n_wait, n_owner;
    bit          n_pend;
    logic [1:0]  xgv;

    @(negedge clk);
    if (req[1] && m_wait == MAXW) w = 1;
    else if (req[0])              w = 0;
    else if (req[1])              w = 1;
    else                          w = -1;
    eg = (w < 0) ? 2'b00 : 2'(1 << w);

    // mem_req is tainted iff flipping some tainted request bits changes |req.
    emt = 1'b0;
    for (int a = 0; a < 4; a++) begin
      logic [1:0] f;
      f = 2'(a);
      if ((f & ~req_t0) == 2'b00 && ((|(req ^ f)) != (|req))) emt = 1'b1;
    end
    egt[0] = req_t0[0] | (req[1] & req_t0[1]);
    egt[1] = req_t0[1] | (req[0] & req_t0[0]);

    e_we = 0; e_we_t0 = 0; e_addr = '0; e_addr_t0 = '0;
    e_wd = '0; e_wd_t0 = '0; e_st = '0; e_st_t0 = '0;
    if (w >= 0) begin
      e_we = we[w];       e_we_t0 = we_t0[w];
      e_addr = addr[w];   e_addr_t0 = addr_t0[w];
      e_wd = wdata[w];    e_wd_t0 = wdata_t0[w];
      e_st = strb[w];     e_st_t0 = strb_t0[w];
    end
    erv  = m_pend ? 2'(1 << m_owner) : 2'b00;
    ervt = m_gt0 & erv;

    chk("gnt", gnt, eg);
    chk("gnt_t0", gnt_t0, egt);
    chk("mem_req", mreq, |req);
    chk("mem_req_t0", mreq_t0, emt);
    chk("mem_we", mwe, e_we);
    chk("mem_we_t0", mwe_t0, e_we_t0);
    chk("mem_addr", maddr, e_addr);
    chk("mem_addr_t0", maddr_t0, e_addr_t0);
    chk("mem_wdata", mwdata, e_wd);
    chk("mem_wdata_t0", mwdata_t0, e_wd_t0);
    chk("mem_strb", mstrb, e_st);
    chk("mem_strb_t0", mstrb_t0, e_st_t0);
    chk("rvalid", rvalid, erv);
    chk("rvalid_t0", rvalid_t0, ervt);
    chk("rdata", rdata, m_pend ? mrdata : '0);
    chk("rdata_t0", rdata_t0, m_pend ? mrdata_t0 : '0);
    if (xg >= 0) begin
      xgv = 2'(xg);
      chk("plan_gnt", gnt, xgv);
    end

    if (req[1] && w != 1) n_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
    else                  n_wait = 0;
    n_pend  = 0;
    n_owner = m_owner;
    if (w >= 0) begin
      if (!we[w]) begin
        n_pend  = 1;
        n_owner = w;
      end
    end

    @(posedge clk);
    #1;
    m_wait  = n_wait;
    m_pend  = n_pend;
    m_owner = n_owner;
    m_gt0   = egt;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    model_reset();

    #2;
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_rvalid", rvalid, 2'b00);
    chk("reset_rvalid_t0", rvalid_t0, 2'b00);
    chk("reset_rdata", rdata, '0);
    chk("reset_rdata_t0", rdata_t0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single core read, data returned next cycle.
    req = 2'b01; we = 2'b00; addr[0] = 32'h8000_0000;
    step(1);
    idle();
    mrdata = 64'hDEAD_BEEF;
    #1;
    chk("t1_rvalid", rvalid, 2'b01);
    chk("t1_rdata", rdata, 64'hDEAD_BEEF);
    step(0);

    // Continuous contention: loader wins every fourth cycle.
    idle();
    req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      addr[0] = $urandom; addr[1] = $urandom;
      step((i % 4 == 3) ? 2 : 1);
    end

    // Loader drops while waiting: counter restarts from zero.
    idle();
    step(0);
    req = 2'b11; step(1); step(1);
    req = 2'b01; step(1);
    req = 2'b11; step(1); step(1); step(1); step(2);

    // Alternating read / write / read.
    idle();
    step(0);
    req = 2'b01; we = 2'b00; step(1);
    req = 2'b10; we = 2'b10; step(2);
    chk("rw_no_rvalid", rvalid, 2'b00);
    req = 2'b01; we = 2'b00; step(1);
    chk("rw_rvalid", rvalid, 2'b01);
    idle();
    step(0);

    // Taint propagation.
    req = 2'b11; req_t0 = 2'b10;
    #1;
    chk("t_gnt_t0_both", gnt_t0, 2'b11);
    chk("t_mreq_t0_both", mreq_t0, 1'b0);
    step(1);
    req = 2'b10; req_t0 = 2'b10; we = 2'b00;
    #1;
    chk("t_mreq_t0_solo", mreq_t0, 1'b1);
    step(2);
    idle();
    mrdata_t0 = 64'hFF;
    #1;
    chk("t_rdata_t0", rdata_t0, 64'hFF);
    step(0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step(-1);
    end

    // Reset with a read in flight.
    idle();
    step(0);
    req = 2'b01; we = 2'b00; mrdata = 64'h1234;
    step(1);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, '0);
    chk("rst_rvalid_t0", rvalid_t0, 2'b00);
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0);
    req = 2'b11;
    step(1); step(1); step(1); step(2);
    idle();
    step(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
